// File: rtl/pc_seq_pkg.sv
// Shared types and elaboration helpers for the program-counter sequencer
// and its return-address stack.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_t;

  localparam int PC_W_DEF      = 7;
  localparam int OFF_W_DEF     = 5;
  localparam int RAS_DEPTH_DEF = 4;

  // A single-entry stack still needs a one-bit pointer.
  function automatic int ras_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int ras_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Number of sign bits added when widening a branch offset to the pc width.
  function automatic int sext_pad_w(input int pc_w, input int off_w);
    return pc_w - off_w;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack: a push onto a full stack overwrites the
// oldest entry; occupancy saturates at RAS_DEPTH.
module return_stack
  import pc_seq_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  localparam int PTR_W = ras_ptr_w(RAS_DEPTH);
  localparam int CNT_W = ras_cnt_w(RAS_DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [PC_W-1:0]  mem_d [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // wr_ptr points at the next free slot; the top entry sits just below it.
  always_comb begin
    top_idx = (wr_ptr_q == '0) ? LAST_IDX : wr_ptr_q - PTR_W'(1);
    top     = mem_q[top_idx];
    full    = (cnt_q == MAX_CNT);
    empty   = (cnt_q == '0);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else if (pop && !empty) begin
      wr_ptr_d = top_idx;
      cnt_d    = cnt_q - CNT_W'(1);
    end else if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PTR_W'(1);
      if (!full) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALT run control, relative branch/call,
// return via hardware stack, stall, and sticky stack error flags.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int OFF_W     = OFF_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    start,
  input  logic [PC_W-1:0]         start_address,
  input  logic                    branch,
  input  logic                    taken,
  input  logic                    call,
  input  logic                    ret,
  input  logic signed [OFF_W-1:0] offset,
  input  logic                    halt,
  input  logic                    stall,
  output logic [PC_W-1:0]         pc,
  output logic                    running,
  output logic                    done,
  output logic                    ras_overflow,
  output logic                    ras_underflow
);

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            st_push, st_pop, st_clear;
  logic [PC_W-1:0] st_top;
  logic            st_full, st_empty;
  logic [PC_W-1:0] pc_inc, pc_rel;

  // Signed widening; the sum below then wraps modulo 2^PC_W in both directions.
  function automatic logic [PC_W-1:0] sext_off(input logic signed [OFF_W-1:0] off);
    logic signed [PC_W-1:0] wide;
    wide = PC_W'(off);
    return wide;
  endfunction

  assign pc_inc = pc_q + PC_W'(1);
  assign pc_rel = pc_q + sext_off(offset);

  return_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (CLK),
    .rst       (reset),
    .push      (st_push),
    .pop       (st_pop),
    .clear     (st_clear),
    .push_data (pc_inc),
    .top       (st_top),
    .full      (st_full),
    .empty     (st_empty)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    st_push  = 1'b0;
    st_pop   = 1'b0;
    st_clear = 1'b0;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d  = RUN;
          pc_d     = start_address;
          st_clear = 1'b1;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
        end
      end
      RUN: begin
        // Priority chain: start > halt > stall > ret > call > taken branch > sequential.
        if (start) begin
          pc_d     = start_address;
          st_clear = 1'b1;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
        end else if (halt) begin
          state_d = HALT;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (ret) begin
          if (st_empty) begin
            unf_d = 1'b1;
            pc_d  = pc_inc;
          end else begin
            st_pop = 1'b1;
            pc_d   = st_top;
          end
        end else if (call) begin
          st_push = 1'b1;
          pc_d    = pc_rel;
          if (st_full) ovf_d = 1'b1;
        end else if (branch && taken) begin
          pc_d = pc_rel;
        end else begin
          pc_d = pc_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign pc            = pc_q;
  assign running       = (state_q == RUN);
  assign done          = (state_q == HALT);
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each cycle queues its expected outputs,
// and each scenario drains and compares them against the captured outputs.
module tb_pc_sequencer;

  typedef struct packed {
    logic [6:0] pc;
    logic       run;
    logic       dn;
    logic       ovf;
    logic       unf;
  } obs_t;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] start_address = '0;
  logic       branch = 1'b0;
  logic       taken = 1'b0;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic [4:0] offset = '0;
  logic       halt = 1'b0;
  logic       stall = 1'b0;
  logic [6:0] pc;
  logic       running, done, ras_overflow, ras_underflow;

  int    errors = 0;
  int    checks = 0;
  obs_t  exp_q[$];
  obs_t  obs_q[$];
  string nm_q[$];

  pc_sequencer #(.PC_W(7), .OFF_W(5), .RAS_DEPTH(4)) dut (
    .CLK           (CLK),
    .reset         (reset),
    .start         (start),
    .start_address (start_address),
    .branch        (branch),
    .taken         (taken),
    .call          (call),
    .ret           (ret),
    .offset        (offset),
    .halt          (halt),
    .stall         (stall),
    .pc            (pc),
    .running       (running),
    .done          (done),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 CLK = ~CLK;

  function automatic obs_t mk(input logic [6:0] p, input logic r, input logic d,
                              input logic o, input logic u);
    obs_t t;
    t.pc = p; t.run = r; t.dn = d; t.ovf = o; t.unf = u;
    return t;
  endfunction

  // Queue the expectation for the inputs currently driven, clock once, capture outputs.
  task automatic tick(input string nm, input obs_t e);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge CLK);
    #1;
    obs_q.push_back({pc, running, done, ras_overflow, ras_underflow});
    start = 0; branch = 0; taken = 0; call = 0; ret = 0; halt = 0; stall = 0;
    offset = '0; start_address = '0;
  endtask

  task automatic test_reset();
    obs_t e, o; string n;
    reset = 1;
    tick("reset0", mk(7'h00, 0, 0, 0, 0));
    start = 1; start_address = 7'h33;
    tick("reset_start_ignored", mk(7'h00, 0, 0, 0, 0));
    reset = 0;
    branch = 1; taken = 1; offset = 5'd4; call = 1;
    tick("idle_ignores_ctl", mk(7'h00, 0, 0, 0, 0));
    tick("idle_holds", mk(7'h00, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got pc=%h run=%b done=%b ovf=%b unf=%b, expected pc=%h run=%b done=%b ovf=%b unf=%b",
                 n, o.pc, o.run, o.dn, o.ovf, o.unf, e.pc, e.run, e.dn, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_start_count();
    obs_t e, o; string n;
    start = 1; start_address = 7'h10;
    tick("start_10", mk(7'h10, 1, 0, 0, 0));
    tick("seq_11", mk(7'h11, 1, 0, 0, 0));
    tick("seq_12", mk(7'h12, 1, 0, 0, 0));
    tick("seq_13", mk(7'h13, 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got pc=%h run=%b done=%b ovf=%b unf=%b, expected pc=%h run=%b done=%b ovf=%b unf=%b",
                 n, o.pc, o.run, o.dn, o.ovf, o.unf, e.pc, e.run, e.dn, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_branch();
    obs_t e, o; string n;
    start = 1; start_address = 7'h02;
    tick("br_start_02", mk(7'h02, 1, 0, 0, 0));
    branch = 1; taken = 1; offset = 5'b11100;
    tick("br_taken_neg", mk(7'h7E, 1, 0, 0, 0));
    start = 1; start_address = 7'h02;
    tick("br_restart_02", mk(7'h02, 1, 0, 0, 0));
    branch = 1; taken = 0; offset = 5'b11100;
    tick("br_not_taken", mk(7'h03, 1, 0, 0, 0));
    branch = 1; taken = 1; offset = 5'h0F;
    tick("br_taken_pos_max", mk(7'h12, 1, 0, 0, 0));
    taken = 1; offset = 5'b11100;
    tick("taken_without_branch", mk(7'h13, 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got pc=%h run=%b done=%b ovf=%b unf=%b, expected pc=%h run=%b done=%b ovf=%b unf=%b",
                 n, o.pc, o.run, o.dn, o.ovf, o.unf, e.pc, e.run, e.dn, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_wrap_stall();
    obs_t e, o; string n;
    start = 1; start_address = 7'h7F;
    tick("wrap_start_7f", mk(7'h7F, 1, 0, 0, 0));
    tick("wrap_up_00", mk(7'h00, 1, 0, 0, 0));
    stall = 1;
    tick("stall_1", mk(7'h00, 1, 0, 0, 0));
    stall = 1;
    tick("stall_2", mk(7'h00, 1, 0, 0, 0));
    stall = 1; call = 1; branch = 1; taken = 1; offset = 5'd4;
    tick("stall_masks_ctl", mk(7'h00, 1, 0, 0, 0));
    tick("after_stall_01", mk(7'h01, 1, 0, 0, 0));
    branch = 1; taken = 1; offset = 5'b11100;
    tick("wrap_down_7d", mk(7'h7D, 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got pc=%h run=%b done=%b ovf=%b unf=%b, expected pc=%h run=%b done=%b ovf=%b unf=%b",
                 n, o.pc, o.run, o.dn, o.ovf, o.unf, e.pc, e.run, e.dn, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_call_ret();
    obs_t e, o; string n;
    start = 1; start_address = 7'h20;
    tick("cr_start_20", mk(7'h20, 1, 0, 0, 0));
    call = 1; offset = 5'd8;
    tick("call_28", mk(7'h28, 1, 0, 0, 0));
    ret = 1;
    tick("ret_21", mk(7'h21, 1, 0, 0, 0));
    ret = 1;
    tick("ret_empty_unf", mk(7'h22, 1, 0, 0, 1));
    tick("unf_sticky", mk(7'h23, 1, 0, 0, 1));
    call = 1; ret = 1; offset = 5'd8;
    tick("call_ret_same_cycle", mk(7'h24, 1, 0, 0, 1));
    ret = 1;
    tick("no_push_on_call_ret", mk(7'h25, 1, 0, 0, 1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got pc=%h run=%b done=%b ovf=%b unf=%b, expected pc=%h run=%b done=%b ovf=%b unf=%b",
                 n, o.pc, o.run, o.dn, o.ovf, o.unf, e.pc, e.run, e.dn, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_overflow();
    obs_t e, o; string n;
    logic [6:0] p;
    logic [6:0] ra;
    start = 1; start_address = 7'h40;
    tick("ovf_start_clears_flags", mk(7'h40, 1, 0, 0, 0));
    p = 7'h40;
    for (int i = 0; i < 5; i++) begin
      call = 1; offset = 5'd2;
      p = p + 7'd2;
      tick($sformatf("nested_call_%0d", i), mk(p, 1, 0, (i == 4), 0));
    end
    // Oldest return address (0x41) was overwritten; remaining LIFO order 49,47,45,43.
    ra = 7'h49;
    for (int i = 0; i < 4; i++) begin
      ret = 1;
      tick($sformatf("lifo_ret_%0d", i), mk(ra, 1, 0, 1, 0));
      ra = ra - 7'd2;
    end
    ret = 1;
    tick("fifth_ret_unf", mk(7'h44, 1, 0, 1, 1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got pc=%h run=%b done=%b ovf=%b unf=%b, expected pc=%h run=%b done=%b ovf=%b unf=%b",
                 n, o.pc, o.run, o.dn, o.ovf, o.unf, e.pc, e.run, e.dn, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o; string n;
    start = 1; start_address = 7'h10;
    tick("b2b_start_10", mk(7'h10, 1, 0, 0, 0));
    call = 1; offset = 5'd4;
    tick("b2b_call_14", mk(7'h14, 1, 0, 0, 0));
    start = 1; start_address = 7'h50;
    tick("restart_50", mk(7'h50, 1, 0, 0, 0));
    ret = 1;
    tick("restart_cleared_stack", mk(7'h51, 1, 0, 0, 1));
    start = 1; halt = 1; start_address = 7'h60;
    tick("start_beats_halt", mk(7'h60, 1, 0, 0, 0));
    halt = 1; stall = 1;
    tick("halt_beats_stall", mk(7'h60, 0, 1, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got pc=%h run=%b done=%b ovf=%b unf=%b, expected pc=%h run=%b done=%b ovf=%b unf=%b",
                 n, o.pc, o.run, o.dn, o.ovf, o.unf, e.pc, e.run, e.dn, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_halt_reset();
    obs_t e, o; string n;
    start = 1; start_address = 7'h2F;
    tick("halt_restart_2f", mk(7'h2F, 1, 0, 0, 0));
    ret = 1;
    tick("pre_halt_unf", mk(7'h30, 1, 0, 0, 1));
    halt = 1;
    tick("halt_30", mk(7'h30, 0, 1, 0, 1));
    for (int i = 0; i < 10; i++) begin
      halt = (i % 2 == 0); call = (i % 3 == 0); branch = 1; taken = 1; offset = 5'd3;
      tick($sformatf("halt_hold_%0d", i), mk(7'h30, 0, 1, 0, 1));
    end
    start = 1; start_address = 7'h05;
    tick("halt_start_05", mk(7'h05, 1, 0, 0, 0));
    tick("run_06", mk(7'h06, 1, 0, 0, 0));
    reset = 1;
    tick("reset_mid_run", mk(7'h00, 0, 0, 0, 0));
    reset = 0;
    tick("idle_after_reset", mk(7'h00, 0, 0, 0, 0));
    start = 1; start_address = 7'h12;
    tick("idle_start_12", mk(7'h12, 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got pc=%h run=%b done=%b ovf=%b unf=%b, expected pc=%h run=%b done=%b ovf=%b unf=%b",
                 n, o.pc, o.run, o.dn, o.ovf, o.unf, e.pc, e.run, e.dn, e.ovf, e.unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_count();
    test_branch();
    test_wrap_stall();
    test_call_ret();
    test_overflow();
    test_back_to_back();
    test_halt_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
